// File: rtl/seq_det_word_scheduler_pkg.sv
// rtl/seq_det_word_scheduler_pkg.sv - shared types and constants for the 0110 word scheduler
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} sched_state_t;

  localparam logic [3:0] DET_PATTERN = 4'b0110;
  localparam int         DET_LEN     = 4;
endpackage

// File: rtl/seq_det_word_scheduler_if.sv
// rtl/seq_det_word_scheduler_if.sv - word in / result out handshake bundle
interface seq_det_word_scheduler_if #(
  parameter int WORD_W = 16
) ();
  localparam int CNT_W = $clog2(WORD_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [WORD_W-1:0] out_mask;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_mask
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_mask
  );
endinterface

// File: rtl/seq_det_word_scheduler_det.sv
// rtl/seq_det_word_scheduler_det.sv - Moore detector for non-overlapping 0110
module sequence_detector_0110 (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic detected
);
  typedef enum logic [2:0] {S_NONE, S_0, S_01, S_011, S_HIT} det_state_t;

  det_state_t state;

  // After a hit the final 0 is consumed, so matching restarts from scratch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_NONE;
    end else begin
      case (state)
        S_NONE:  state <= data_in ? S_NONE : S_0;
        S_0:     state <= data_in ? S_01   : S_0;
        S_01:    state <= data_in ? S_011  : S_0;
        S_011:   state <= data_in ? S_NONE : S_HIT;
        S_HIT:   state <= data_in ? S_NONE : S_0;
        default: state <= S_NONE;
      endcase
    end
  end

  assign detected = (state == S_HIT);
endmodule

// File: rtl/seq_det_word_scheduler.sv
// rtl/seq_det_word_scheduler.sv - shifts words MSB-first into a fresh 0110 detector
// and reports per-word hit count and hit mask.
module seq_det_word_scheduler
  import seq_det_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  seq_det_word_scheduler_if.slave  bus
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORD_W - 1);

  sched_state_t      state;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  cap_idx;
  logic              det_rst;
  logic              det_bit;
  logic              det_reset;
  logic              detected;
  logic              in_ready;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic [WORD_W-1:0] out_mask;

  assign det_reset = reset | det_rst;

  sequence_detector_0110 u_det (
    .clk      (clk),
    .reset    (det_reset),
    .data_in  (det_bit),
    .detected (detected)
  );

  // detected lags the driven bit by one cycle, so hits are attributed via cap_idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      cap_idx   <= '0;
      det_rst   <= 1'b1;
      det_bit   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_count <= '0;
      out_mask  <= '0;
    end else begin
      cap_idx <= idx;
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            shreg     <= bus.in_data;
            det_bit   <= bus.in_data[WORD_W-1];
            det_rst   <= 1'b0;
            out_count <= '0;
            out_mask  <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (detected) begin
            out_mask[LAST - cap_idx] <= 1'b1;
            out_count                <= out_count + CNT_W'(1);
          end
          if (idx == LAST) begin
            state <= DRAIN;
          end else begin
            shreg   <= shreg << 1;
            det_bit <= shreg[WORD_W-2];
            idx     <= idx + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (detected) begin
            out_mask[LAST - cap_idx] <= 1'b1;
            out_count                <= out_count + CNT_W'(1);
          end
          out_valid <= 1'b1;
          det_rst   <= 1'b1;
          det_bit   <= 1'b0;
          state     <= REPORT;
        end
        REPORT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_count = out_count;
  assign bus.out_mask  = out_mask;
endmodule

// File: tb/tb_seq_det_word_scheduler.sv
// tb/tb_seq_det_word_scheduler.sv - directed bench for seq_det_word_scheduler
module tb_seq_det_word_scheduler;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  int   seen;

  seq_det_word_scheduler_if #(.WORD_W(16)) bus ();

  seq_det_word_scheduler #(.WORD_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accept edge; waits for the result, checks it, retires it.
  task automatic wait_result(input string tag, input int exp_cnt, input logic [15:0] exp_mask);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, 17);
    check({tag, " count"}, bus.out_count, exp_cnt);
    check({tag, " mask"}, bus.out_mask, exp_mask);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, " retire out_valid"}, bus.out_valid, 0);
    check({tag, " retire in_ready"}, bus.in_ready, 1);
  endtask

  task automatic run_word(input string tag, input logic [15:0] d, input int exp_cnt,
                          input logic [15:0] exp_mask);
    @(negedge clk);
    check({tag, " in_ready idle"}, bus.in_ready, 1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, " in_ready busy"}, bus.in_ready, 0);
    wait_result(tag, exp_cnt, exp_mask);
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_count", bus.out_count, 0);
    check("reset out_mask", bus.out_mask, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run_word("w6000", 16'h6000, 1, 16'h1000);
    run_word("w6666", 16'h6666, 4, 16'h1111);
    run_word("w7777", 16'h7777, 0, 16'h0000);
    run_word("wFFFF", 16'hFFFF, 0, 16'h0000);
    run_word("w0003", 16'h0003, 0, 16'h0000);
    run_word("w0000 isolated", 16'h0000, 0, 16'h0000);

    // Back-pressure with in_valid held high, then simultaneous retire/offer.
    @(negedge clk);
    bus.in_data  = 16'h0006;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_data = 16'h6666;
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 40) begin
        @(posedge clk);
        #1;
        if (bus.in_ready !== 1'b0) seen++;
        n++;
      end
      check("bp latency", n, 17);
      check("bp in_ready low during shift", seen, 0);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp out_valid", bus.out_valid, 1);
      check("bp count", bus.out_count, 1);
      check("bp mask", bus.out_mask, 16'h0001);
      check("bp in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("simul out_valid", bus.out_valid, 0);
    check("simul not yet accepted", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("simul accepted", bus.in_ready, 0);
    wait_result("simul w6666", 4, 16'h1111);

    // Reset in the middle of SHIFT discards the word.
    @(negedge clk);
    bus.in_data  = 16'h6000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset in_ready async", bus.in_ready, 1);
    check("midreset out_valid async", bus.out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("postreset in_ready", bus.in_ready, 1);
    check("postreset out_valid", bus.out_valid, 0);
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    check("postreset no result", seen, 0);
    run_word("w0006 after reset", 16'h0006, 1, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
